// File: rtl/eco_vec_sweeper_if.sv
// Operand/result bus between the sweeper and the two netlists under ECO test.
// The sweeper (master) drives a/b; both netlists (slave side) return y.
`timescale 1ns/1ps

interface eco_vec_sweeper_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y_dut;
    logic [WIDTH-1:0] y_gold;

    modport master (
        output a,
        output b,
        input  y_dut,
        input  y_gold
    );

    modport slave (
        input  a,
        input  b,
        output y_dut,
        output y_gold
    );
endinterface

// File: rtl/eco_vec_sweeper.sv
// Exhaustive (a,b) sweep of a patched netlist against its golden copy.
// Counts mismatching vectors and records the first failing {b,a}.
`timescale 1ns/1ps

module eco_vec_sweeper #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    eco_vec_sweeper_if.master    bus,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     mism_cnt,
    output logic [2*WIDTH-1:0]   first_fail_vec,
    output logic                 first_fail_valid
);
    localparam int VW = 2 * WIDTH;
    localparam int MW = VW + 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [CW-1:0] C_LAST = (SETTLE > 0) ? CW'(SETTLE - 1) : '0;
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [VW-1:0] V_ONE  = VW'(1);
    localparam logic [MW-1:0] M_ONE  = MW'(1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CMP,
        DONE
    } state_t;

    // With no settle time each vector is compared on the cycle it appears.
    localparam state_t FIRST = (SETTLE == 0) ? CMP : DRIVE;

    state_t          state_q, state_n;
    logic [VW-1:0]   v_q, v_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic [MW-1:0]   mism_q, mism_n;
    logic [VW-1:0]   ffv_q, ffv_n;
    logic            ffval_q, ffval_n;
    logic            busy_q, busy_n;
    logic            done_q, done_n;
    logic            pass_q, pass_n;
    logic            mismatch;

    assign mismatch = (bus.y_dut != bus.y_gold);

    // Next-state and next-result logic; every register holds unless updated.
    always_comb begin
        state_n = state_q;
        v_n     = v_q;
        cnt_n   = cnt_q;
        mism_n  = mism_q;
        ffv_n   = ffv_q;
        ffval_n = ffval_q;
        busy_n  = busy_q;
        done_n  = done_q;
        pass_n  = pass_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_n = FIRST;
                    v_n     = '0;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    pass_n  = 1'b0;
                    mism_n  = '0;
                    ffv_n   = '0;
                    ffval_n = 1'b0;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                    done_n  = 1'b0;
                    pass_n  = 1'b0;
                end else if (cnt_q == C_LAST) begin
                    state_n = CMP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + C_ONE;
                end
            end
            CMP: begin
                if (abort) begin
                    // The compare of this cycle is dropped on abort.
                    state_n = IDLE;
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                    done_n  = 1'b0;
                    pass_n  = 1'b0;
                end else begin
                    if (mismatch) begin
                        mism_n = mism_q + M_ONE;
                        if (!ffval_q) begin
                            ffv_n   = v_q;
                            ffval_n = 1'b1;
                        end
                    end
                    if (&v_q) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = (mism_n == '0);
                    end else begin
                        v_n     = v_q + V_ONE;
                        state_n = FIRST;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, vector index, settle counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            v_q     <= '0;
            cnt_q   <= '0;
            mism_q  <= '0;
            ffv_q   <= '0;
            ffval_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            v_q     <= v_n;
            cnt_q   <= cnt_n;
            mism_q  <= mism_n;
            ffv_q   <= ffv_n;
            ffval_q <= ffval_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            pass_q  <= pass_n;
        end
    end

    assign bus.a            = v_q[WIDTH-1:0];
    assign bus.b            = v_q[VW-1:WIDTH];
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign mism_cnt         = mism_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffval_q;

endmodule

// File: tb/tb_eco_vec_sweeper.sv
// Bench for eco_vec_sweeper: SETTLE=1 and SETTLE=0 instances, golden y=a+b,
// patched netlist with selectable fault injection.
`timescale 1ns/1ps

module tb_eco_vec_sweeper;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] start;
    logic [1:0] abort;
    wire  [1:0] busy;
    wire  [1:0] done;
    wire  [1:0] pass;
    wire  [1:0] ffval;
    wire  [8:0] mism [2];
    wire  [7:0] ffv  [2];

    logic [1:0] mode0, mode1;
    logic [7:0] tgt0, tgt1;
    logic [3:0] inj0, inj1;

    int nerr = 0;
    int nchk = 0;

    eco_vec_sweeper_if #(.WIDTH(4)) bus0 ();
    eco_vec_sweeper_if #(.WIDTH(4)) bus1 ();

    assign inj0 = (mode0 == 2'd2) ? 4'hF :
                  (mode0 == 2'd1 && {bus0.b, bus0.a} == tgt0) ? 4'h2 : 4'h0;
    assign inj1 = (mode1 == 2'd2) ? 4'hF :
                  (mode1 == 2'd1 && {bus1.b, bus1.a} == tgt1) ? 4'h2 : 4'h0;

    assign bus0.y_gold = bus0.a + bus0.b;
    assign bus0.y_dut  = bus0.y_gold ^ inj0;
    assign bus1.y_gold = bus1.a + bus1.b;
    assign bus1.y_dut  = bus1.y_gold ^ inj1;

    eco_vec_sweeper #(.WIDTH(4), .SETTLE(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
        .bus(bus0), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .mism_cnt(mism[0]), .first_fail_vec(ffv[0]),
        .first_fail_valid(ffval[0])
    );

    eco_vec_sweeper #(.WIDTH(4), .SETTLE(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
        .bus(bus1), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .mism_cnt(mism[1]), .first_fail_vec(ffv[1]),
        .first_fail_valid(ffval[1])
    );

    always #5 clk = ~clk;

    typedef struct {
        int inst;
        int mode;
        int tgt;
        int cyc;
        int pas;
        int mis;
        int fv;
        int fvl;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int get_v(input int i);
        if (i == 0) return int'({bus0.b, bus0.a});
        return int'({bus1.b, bus1.a});
    endfunction

    task automatic set_mode(input int i, input int m, input int t);
        if (i == 0) begin
            mode0 = 2'(m);
            tgt0  = 8'(t);
        end else begin
            mode1 = 2'(m);
            tgt1  = 8'(t);
        end
    endtask

    task automatic run(input int i, output int cyc);
        int bad;
        cyc = 0;
        bad = 0;
        @(posedge clk); #1 start[i] = 1'b1;
        @(posedge clk); #1 start[i] = 1'b0;
        chk("first_vec", get_v(i), 0);
        while (busy[i] && cyc < 2000) begin
            if (i == 1 && get_v(1) != (cyc & 255)) bad++;
            cyc++;
            @(posedge clk); #1;
        end
        if (i == 1) chk("a_b_step", bad, 0);
    endtask

    task automatic results(input int i, input int pe, input int me,
                           input int fe, input int fle);
        chk("busy_end", int'(busy[i]), 0);
        chk("done", int'(done[i]), 1);
        chk("pass", int'(pass[i]), pe);
        chk("mism_cnt", int'(mism[i]), me);
        chk("first_fail_vec", int'(ffv[i]), fe);
        chk("first_fail_valid", int'(ffval[i]), fle);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        tbl[0] = '{0, 0, 0,    512, 1, 0,   0,    0};
        tbl[1] = '{0, 1, 'h35, 512, 0, 1,   'h35, 1};
        tbl[2] = '{0, 2, 0,    512, 0, 256, 0,    1};
        tbl[3] = '{1, 0, 0,    256, 1, 0,   0,    0};
        tbl[4] = '{1, 1, 'hFF, 256, 0, 1,   'hFF, 1};
        tbl[5] = '{1, 2, 0,    256, 0, 256, 0,    1};

        rst_n = 1'b0;
        start = 2'b00;
        abort = 2'b00;
        set_mode(0, 0, 0);
        set_mode(1, 0, 0);
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_ab", get_v(0), 0);
        chk("rst_mism", int'(mism[0]), 0);
        chk("rst_ffv", int'(ffv[0]), 0);
        chk("rst_ffval", int'(ffval), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int k = 0; k < 6; k++) begin
            set_mode(tbl[k].inst, tbl[k].mode, tbl[k].tgt);
            run(tbl[k].inst, c);
            chk("busy_cycles", c, tbl[k].cyc);
            results(tbl[k].inst, tbl[k].pas, tbl[k].mis,
                    tbl[k].fv, tbl[k].fvl);
        end

        // Abort landing on a compare cycle discards that compare.
        set_mode(1, 1, 'h05);
        @(posedge clk); #1 start[1] = 1'b1;
        @(posedge clk); #1 start[1] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("cmp_abort_pre_v", get_v(1), 5);
        abort[1] = 1'b1;
        @(posedge clk); #1 abort[1] = 1'b0;
        chk("cmp_abort_busy", int'(busy[1]), 0);
        chk("cmp_abort_done", int'(done[1]), 0);
        chk("cmp_abort_mism", int'(mism[1]), 0);
        chk("cmp_abort_ffval", int'(ffval[1]), 0);
        chk("cmp_abort_v", get_v(1), 5);

        // Abort at cycle 40 holds the debug data and operands.
        set_mode(0, 1, 'h05);
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        repeat (40) @(posedge clk);
        #1 abort[0] = 1'b1;
        @(posedge clk); #1 abort[0] = 1'b0;
        chk("abort_busy", int'(busy[0]), 0);
        chk("abort_done", int'(done[0]), 0);
        chk("abort_pass", int'(pass[0]), 0);
        chk("abort_mism", int'(mism[0]), 1);
        chk("abort_ffv", int'(ffv[0]), 'h05);
        chk("abort_ffval", int'(ffval[0]), 1);
        chk("abort_v", get_v(0), 20);
        abort[0] = 1'b1;
        @(posedge clk); #1 abort[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_abort_busy", int'(busy[0]), 0);
        chk("idle_abort_ffv", int'(ffv[0]), 'h05);
        chk("idle_abort_mism", int'(mism[0]), 1);
        chk("idle_abort_v", get_v(0), 20);
        set_mode(0, 0, 0);
        run(0, c);
        chk("rerun_cycles", c, 512);
        results(0, 1, 0, 0, 0);

        // start and abort together in DONE: start wins.
        @(posedge clk); #1 start[0] = 1'b1; abort[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0; abort[0] = 1'b0;
        chk("both_busy", int'(busy[0]), 1);
        chk("both_done", int'(done[0]), 0);
        abort[0] = 1'b1;
        @(posedge clk); #1 abort[0] = 1'b0;
        chk("both_abort_busy", int'(busy[0]), 0);

        // Second start mid-sweep is ignored; reset discards everything.
        set_mode(0, 1, 'h05);
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("restart_ignored_v", get_v(0), 10);
        chk("restart_busy", int'(busy[0]), 1);
        repeat (79) @(posedge clk);
        #1;
        chk("pre_rst_mism", int'(mism[0]), 1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy[0]), 0);
        chk("mid_rst_ab", get_v(0), 0);
        chk("mid_rst_mism", int'(mism[0]), 0);
        chk("mid_rst_ffv", int'(ffv[0]), 0);
        chk("mid_rst_ffval", int'(ffval[0]), 0);
        chk("mid_rst_done", int'(done[0]), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        set_mode(0, 0, 0);
        run(0, c);
        chk("post_rst_cycles", c, 512);
        results(0, 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
